// File: rtl/shader_issue_unit_pkg.sv
// Purpose: shared types for the shader issue path. Defines the data word, the ALU opcode set,
//          the instruction word layout, the issue FSM states, and an opcode legality helper.
// Ports:   none (package).
package shader_issue_unit_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned RSVD_W    = 4;
  localparam int unsigned IMMD_W    = 11;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned DMEM_AW   = $clog2(MEM_DEPTH);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_LOAD  = 5'd6,
    OP_STORE = 5'd7
  } opcodes_t;

  // Opcode is kept as raw bits so undecodable values survive into IR.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs0;
    logic [REG_IDX_W-1:0] rs1;
    logic [RSVD_W-1:0]    rsvd;
    logic [IMMD_W-1:0]    immd;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_FIN    = 3'd4
  } issue_state_t;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_STORE: legal = 1'b1;
      default:                                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/shader_regfile.sv
// Purpose: shader local register file, one synchronous write port, three asynchronous
//          read ports (two operands plus debug), synchronous active-high clear.
// Ports:   i_clk, i_rst            clock, synchronous active-high reset
//          i_we/i_waddr/i_wdata    write port
//          i_raddr0/o_rdata0       operand 0 read
//          i_raddr1/o_rdata1       operand 1 read
//          i_raddr_dbg/o_rdata_dbg debug read
module shader_regfile
  import shader_issue_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  word_t                i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr0,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  input  logic [REG_IDX_W-1:0] i_raddr_dbg,
  output word_t                o_rdata0,
  output word_t                o_rdata1,
  output word_t                o_rdata_dbg
);

  word_t r_regs [NUM_REGS];

  // Write port with whole-array clear on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0    = r_regs[i_raddr0];
  assign o_rdata1    = r_regs[i_raddr1];
  assign o_rdata_dbg = r_regs[i_raddr_dbg];

endmodule

// File: rtl/shader_issue_unit.sv
// Purpose: instruction issue/sequencing engine driving the combinational ALU. Fetches from a
//          1-cycle instruction memory, decodes, strobes the data-memory read for LOADs, presents
//          operands to the ALU and commits its write-back. Three cycles per instruction.
// Ports:   i_clk, i_rst                       clock, synchronous active-high reset
//          i_start, i_prog_len                run request and instruction count
//          o_busy, o_done                     run status, one-cycle completion pulse
//          o_imem_addr, i_imem_rdata          instruction fetch
//          o_dmem_rd_en, o_dmem_rd_addr       data-memory read request (LOAD)
//          o_alu_*                            operands, opcode, immediate to the ALU
//          i_alu_reg_write_en/_data           ALU write-back
//          o_illegal_op, o_instr_count        sticky illegal flag, retired count
//          i_dbg_reg_idx, o_dbg_reg_data      combinational register peek
module shader_issue_unit
  import shader_issue_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned PC_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [PC_W-1:0]      i_prog_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [PC_W-1:0]      o_imem_addr,
  input  word_t                i_imem_rdata,
  output logic                 o_dmem_rd_en,
  output logic [DMEM_AW-1:0]   o_dmem_rd_addr,
  output word_t                o_alu_read_reg0,
  output word_t                o_alu_read_reg1,
  output opcodes_t             o_alu_opcode,
  output logic [IMMD_W-1:0]    o_alu_immd,
  input  logic                 i_alu_reg_write_en,
  input  word_t                i_alu_reg_write_data,
  output logic                 o_illegal_op,
  output logic [PC_W-1:0]      o_instr_count,
  input  logic [REG_IDX_W-1:0] i_dbg_reg_idx,
  output word_t                o_dbg_reg_data
);

  issue_state_t    r_state;
  issue_state_t    w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_prog_len;
  logic [PC_W-1:0] r_instr_count;
  logic            r_illegal_op;
  instr_t          r_ir;

  instr_t          w_fetched;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_ir_legal;
  logic            w_rf_we;
  logic            w_unused_rsvd;

  assign w_fetched     = instr_t'(i_imem_rdata);
  assign w_pc_inc      = r_pc + PC_W'(1);
  assign w_ir_legal    = is_legal_op(r_ir.opcode);
  assign w_rf_we       = (r_state == ST_EXEC) && i_alu_reg_write_en;
  assign w_unused_rsvd = ^r_ir.rsvd;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next_state   = r_state;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_dmem_rd_en   = 1'b0;
    o_dmem_rd_addr = '0;
    o_alu_opcode   = OP_NOP;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = (i_prog_len == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_busy       = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        o_busy       = 1'b1;
        w_next_state = ST_EXEC;
        // IR is not loaded yet, so the read request comes straight off the fetch bus.
        if (w_fetched.opcode == OP_LOAD) begin
          o_dmem_rd_en   = 1'b1;
          o_dmem_rd_addr = w_fetched.immd[DMEM_AW-1:0];
        end
      end
      ST_EXEC: begin
        o_busy       = 1'b1;
        w_next_state = (w_pc_inc == r_prog_len) ? ST_FIN : ST_FETCH;
        if (w_ir_legal) begin
          o_alu_opcode = opcodes_t'(r_ir.opcode);
        end
      end
      ST_FIN: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // PC, IR, retire counter and sticky illegal flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= '0;
      r_prog_len    <= '0;
      r_instr_count <= '0;
      r_illegal_op  <= 1'b0;
      r_ir          <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_prog_len    <= i_prog_len;
            r_pc          <= '0;
            r_instr_count <= '0;
            r_illegal_op  <= 1'b0;
          end
        end
        ST_DECODE: begin
          r_ir <= w_fetched;
        end
        ST_EXEC: begin
          r_pc          <= w_pc_inc;
          r_instr_count <= r_instr_count + PC_W'(1);
          if (!w_ir_legal) begin
            r_illegal_op <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  shader_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (w_rf_we),
    .i_waddr     (r_ir.rd),
    .i_wdata     (i_alu_reg_write_data),
    .i_raddr0    (r_ir.rs0),
    .i_raddr1    (r_ir.rs1),
    .i_raddr_dbg (i_dbg_reg_idx),
    .o_rdata0    (o_alu_read_reg0),
    .o_rdata1    (o_alu_read_reg1),
    .o_rdata_dbg (o_dbg_reg_data)
  );

  assign o_imem_addr   = r_pc;
  assign o_alu_immd    = r_ir.immd;
  assign o_illegal_op  = r_illegal_op;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_shader_issue_unit.sv
// Purpose: directed self-checking bench for shader_issue_unit with behavioural 1-cycle
//          instruction/data memories and a small behavioural ALU.
module tb_shader_issue_unit;
  import shader_issue_unit_pkg::*;

  localparam int unsigned PC_W = 8;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_start;
  logic [PC_W-1:0]      i_prog_len;
  logic                 o_busy;
  logic                 o_done;
  logic [PC_W-1:0]      o_imem_addr;
  word_t                imem_rdata;
  logic                 o_dmem_rd_en;
  logic [DMEM_AW-1:0]   o_dmem_rd_addr;
  word_t                o_alu_read_reg0;
  word_t                o_alu_read_reg1;
  opcodes_t             o_alu_opcode;
  logic [IMMD_W-1:0]    o_alu_immd;
  logic                 alu_we;
  word_t                alu_wdata;
  logic                 o_illegal_op;
  logic [PC_W-1:0]      o_instr_count;
  logic [REG_IDX_W-1:0] i_dbg_reg_idx;
  word_t                o_dbg_reg_data;

  logic                 alu_mem_we;
  logic [DMEM_AW-1:0]   alu_mem_addr;
  word_t                alu_mem_wdata;
  word_t                dmem_rdata;

  word_t imem [256];
  word_t dmem [256];

  int checks   = 0;
  int failures = 0;

  // Per-run observations.
  int    done_cnt, busy_seen, rd_en_cnt, rd_en_cyc, wr_cnt, wr_cyc;
  int    rd_en_addr, wr_addr;
  word_t wr_data;
  int    cyc;
  word_t rv;

  always #5 clk = ~clk;

  shader_issue_unit #(.NUM_REGS(16), .PC_W(PC_W)) dut (
    .i_clk                (clk),
    .i_rst                (i_rst),
    .i_start              (i_start),
    .i_prog_len           (i_prog_len),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_imem_addr          (o_imem_addr),
    .i_imem_rdata         (imem_rdata),
    .o_dmem_rd_en         (o_dmem_rd_en),
    .o_dmem_rd_addr       (o_dmem_rd_addr),
    .o_alu_read_reg0      (o_alu_read_reg0),
    .o_alu_read_reg1      (o_alu_read_reg1),
    .o_alu_opcode         (o_alu_opcode),
    .o_alu_immd           (o_alu_immd),
    .i_alu_reg_write_en   (alu_we),
    .i_alu_reg_write_data (alu_wdata),
    .o_illegal_op         (o_illegal_op),
    .o_instr_count        (o_instr_count),
    .i_dbg_reg_idx        (i_dbg_reg_idx),
    .o_dbg_reg_data       (o_dbg_reg_data)
  );

  // 1-cycle instruction memory.
  always @(posedge clk) imem_rdata <= imem[o_imem_addr];

  // 1-cycle data memory read port plus ALU store port.
  always @(posedge clk) begin
    if (o_dmem_rd_en) dmem_rdata <= dmem[o_dmem_rd_addr];
    if (alu_mem_we)   dmem[alu_mem_addr] <= alu_mem_wdata;
  end

  // Behavioural ALU: ADD/LOAD write back, STORE writes memory.
  always_comb begin
    alu_we        = 1'b0;
    alu_wdata     = '0;
    alu_mem_we    = 1'b0;
    alu_mem_addr  = '0;
    alu_mem_wdata = '0;
    case (o_alu_opcode)
      OP_ADD: begin
        alu_we    = 1'b1;
        alu_wdata = o_alu_read_reg0 + o_alu_read_reg1;
      end
      OP_LOAD: begin
        alu_we    = 1'b1;
        alu_wdata = dmem_rdata;
      end
      OP_STORE: begin
        alu_mem_we    = 1'b1;
        alu_mem_addr  = o_alu_immd[DMEM_AW-1:0];
        alu_mem_wdata = o_alu_read_reg0;
      end
      default: begin
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic word_t enc(input logic [4:0] op, input logic [3:0] rd,
                                input logic [3:0] rs0, input logic [3:0] rs1,
                                input logic [10:0] immd);
    return {op, rd, rs0, rs1, 4'b0000, immd};
  endfunction

  task automatic rd_reg(input int idx, output word_t val);
    i_dbg_reg_idx = REG_IDX_W'(idx);
    #1;
    val = o_dbg_reg_data;
  endtask

  // Pulses start, then samples every cycle #1 after the edge. rst_at/restart_at inject a
  // reset (with start) or a second start at that cycle. cyc is the cycle index of done.
  task automatic run(input int len, input int rst_at, input int restart_at);
    done_cnt = 0; busy_seen = 0; rd_en_cnt = 0; rd_en_cyc = 0; wr_cnt = 0; wr_cyc = 0;
    rd_en_addr = 0; wr_addr = 0; wr_data = '0; cyc = 0;
    i_prog_len = PC_W'(len);
    i_start    = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_rst   = 1'b0;
      if (o_busy) busy_seen = 1;
      if (o_dmem_rd_en) begin
        rd_en_cnt++;
        rd_en_cyc  = n;
        rd_en_addr = int'(o_dmem_rd_addr);
      end
      if (alu_mem_we) begin
        wr_cnt++;
        wr_cyc  = n;
        wr_addr = int'(alu_mem_addr);
        wr_data = alu_mem_wdata;
      end
      if (o_done) begin
        done_cnt++;
        if (cyc == 0) cyc = n;
      end
      if (n == rst_at) begin
        i_rst   = 1'b1;
        i_start = 1'b1;
      end
      if (n == restart_at) begin
        i_start    = 1'b1;
        i_prog_len = PC_W'(5);
      end
      if (cyc != 0 && n >= cyc + 3) break;
    end
  endtask

  task automatic load_add_chain();
    dmem[0] = 32'd20;
    dmem[1] = 32'd5;
    imem[0] = enc(5'(OP_LOAD), 4'd1, 4'd0, 4'd0, 11'd0);
    imem[1] = enc(5'(OP_LOAD), 4'd2, 4'd0, 4'd0, 11'd1);
    imem[2] = enc(5'(OP_ADD),  4'd3, 4'd1, 4'd2, 11'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
    i_rst = 1'b1; i_start = 1'b0; i_prog_len = '0; i_dbg_reg_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rd_en", 32'(o_dmem_rd_en), 32'd0);
    chk("rst_opcode", 32'(o_alu_opcode), 32'(OP_NOP));
    chk("rst_illegal", 32'(o_illegal_op), 32'd0);
    chk("rst_count", 32'(o_instr_count), 32'd0);
    i_rst = 1'b0;
    rd_reg(3, rv); chk("rst_r3", rv, 32'd0);

    // 1: LOAD/LOAD/ADD chain
    load_add_chain();
    run(3, -1, -1);
    chk("t1_done_cyc", 32'(cyc), 32'd10);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_busy_seen", 32'(busy_seen), 32'd1);
    chk("t1_busy_after", 32'(o_busy), 32'd0);
    chk("t1_count", 32'(o_instr_count), 32'd3);
    rd_reg(3, rv); chk("t1_r3", rv, 32'd25);

    // 2: single LOAD, read strobe in DECODE
    dmem[11] = 32'd12345;
    imem[0]  = enc(5'(OP_LOAD), 4'd4, 4'd0, 4'd0, 11'd11);
    run(1, -1, -1);
    chk("t2_done_cyc", 32'(cyc), 32'd4);
    chk("t2_rd_en_cnt", 32'(rd_en_cnt), 32'd1);
    chk("t2_rd_en_cyc", 32'(rd_en_cyc), 32'd2);
    chk("t2_rd_addr", 32'(rd_en_addr), 32'd11);
    rd_reg(4, rv); chk("t2_r4", rv, 32'd12345);

    // 3: STORE of R5 to address 11, rd field must not be written
    dmem[20] = 32'd777;
    imem[0]  = enc(5'(OP_LOAD),  4'd5, 4'd0, 4'd0, 11'd20);
    imem[1]  = enc(5'(OP_STORE), 4'd6, 4'd5, 4'd0, 11'd11);
    run(2, -1, -1);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("t3_wr_cyc", 32'(wr_cyc), 32'd6);
    chk("t3_wr_addr", 32'(wr_addr), 32'd11);
    chk("t3_wr_data", wr_data, 32'd777);
    chk("t3_dmem11", dmem[11], 32'd777);
    rd_reg(6, rv); chk("t3_r6", rv, 32'd0);
    rd_reg(4, rv); chk("t3_r4", rv, 32'd12345);

    // 4: empty program
    run(0, -1, -1);
    chk("t4_done_cyc", 32'(cyc), 32'd1);
    chk("t4_busy_seen", 32'(busy_seen), 32'd0);
    chk("t4_rd_en_cnt", 32'(rd_en_cnt), 32'd0);
    chk("t4_count", 32'(o_instr_count), 32'd0);

    // 5: reset during DECODE of instruction 2 (start held in reset cycle), then rerun
    load_add_chain();
    run(3, 5, -1);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_count", 32'(o_instr_count), 32'd0);
    rd_reg(1, rv); chk("t5_r1", rv, 32'd0);
    rd_reg(4, rv); chk("t5_r4", rv, 32'd0);
    rd_reg(5, rv); chk("t5_r5", rv, 32'd0);
    run(3, -1, -1);
    chk("t5_rerun_cyc", 32'(cyc), 32'd10);
    chk("t5_rerun_count", 32'(o_instr_count), 32'd3);
    rd_reg(3, rv); chk("t5_rerun_r3", rv, 32'd25);

    // 6: illegal opcode retires without side effects; next start clears the flag
    imem[0] = enc(5'h1F, 4'd7, 4'd1, 4'd2, 11'd3);
    imem[1] = enc(5'(OP_ADD), 4'd8, 4'd1, 4'd2, 11'd0);
    run(2, -1, -1);
    chk("t6_done_cyc", 32'(cyc), 32'd7);
    chk("t6_illegal", 32'(o_illegal_op), 32'd1);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("t6_count", 32'(o_instr_count), 32'd2);
    rd_reg(7, rv); chk("t6_r7", rv, 32'd0);
    rd_reg(8, rv); chk("t6_r8", rv, 32'd25);
    imem[0] = enc(5'(OP_ADD), 4'd9, 4'd1, 4'd2, 11'd0);
    run(1, -1, -1);
    chk("t6_illegal_clr", 32'(o_illegal_op), 32'd0);
    rd_reg(9, rv); chk("t6_r9", rv, 32'd25);

    // 7: start while busy with a longer prog_len is ignored
    imem[0] = enc(5'(OP_ADD), 4'd10, 4'd1,  4'd2, 11'd0);
    imem[1] = enc(5'(OP_ADD), 4'd11, 4'd10, 4'd1, 11'd0);
    imem[2] = enc(5'(OP_ADD), 4'd12, 4'd1,  4'd1, 11'd0);
    run(2, -1, 3);
    chk("t7_done_cyc", 32'(cyc), 32'd7);
    chk("t7_done_cnt", 32'(done_cnt), 32'd1);
    chk("t7_count", 32'(o_instr_count), 32'd2);
    rd_reg(11, rv); chk("t7_r11", rv, 32'd45);
    rd_reg(12, rv); chk("t7_r12", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
